acu_alu_stage: RTL and testbench

//  Execution stage directly upstream of the accumulator (ACU). Takes an opcode plus operands A
//  (accumulator out_val fed back) and B, computes the result, and presents it on res_val

---
 rtl/salamander_pkg.sv | 37 +++
 rtl/acu_mul_iter.sv | 65 ++++++
 rtl/acu_alu_stage.sv | 147 ++++++++++++++
 tb/tb_acu_alu_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/salamander_pkg.sv
// Shared definitions for the accumulator datapath: ALU opcode encoding,
// positions of the C/Z/N bits inside the flag register, the ALU stage
// FSM states, and a helper that assembles the flag vector.
package salamander_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } opcode_e;

  localparam int NUM_FLAGS = 3;
  localparam int FLAG_C    = 2;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_N    = 0;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } alu_state_e;

  function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic c, input logic z,
                                                      input logic n);
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/acu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset (aborts a multiply)
//   start          latch a_val/b_val and begin; ignored bits of a running op
//   a_val, b_val   operands, sampled only on start
//   done           high during the cycle whose closing edge performs step SIZE
//   product        full 2*SIZE product, valid while done is high
// The final accumulate is presented combinationally with done so the caller
// can capture the result on the same edge that performs the last step.
module acu_mul_iter #(
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [SIZE-1:0]   a_val,
  input  logic [SIZE-1:0]   b_val,
  output logic              done,
  output logic [2*SIZE-1:0] product
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [2*SIZE-1:0] acc_q;
  logic [2*SIZE-1:0] mcand_q;
  logic [2*SIZE-1:0] acc_next;
  logic [SIZE-1:0]   mplier_q;
  logic [CW-1:0]     cnt_q;
  logic              run_q;

  always_comb begin
    acc_next = acc_q;
    if (mplier_q[0]) begin
      acc_next = acc_q + mcand_q;
    end
  end

  assign done    = run_q && (cnt_q == CW'(SIZE - 1));
  assign product = acc_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{SIZE{1'b0}}, a_val};
      mplier_q <= b_val;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/acu_alu_stage.sv
// ALU execution stage feeding the accumulator (ACU). Computes opcode(a_val,
// b_val), registers the result on res_val with a one-cycle res_ce pulse that
// drives the ACU CE/in_val pair, and keeps a {C,Z,N} flag register.
// Configuration macro: SALAMANDER_ALU_MUL_EN enables opcode 111 as an
// iterative unsigned multiply (MUL_BUSY state + acu_mul_iter). Without it,
// opcode 111 is a single-cycle NOP that passes a_val through.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   op_valid/ready   operation handshake
//   opcode           operation select (salamander_pkg::opcode_e)
//   a_val, b_val     operands (a_val is the ACU output fed back)
//   res_val, res_ce  registered result and its one-cycle valid pulse
//   flags            registered {C,Z,N}, updated only with res_ce
//   state_dbg        current FSM state, for observation only
// Handshake: an op transfers on a rising clk edge where op_valid and
// op_ready are both high; op_ready never depends on op_valid, and an op
// offered while op_ready is low is ignored (upstream must hold it).
module acu_alu_stage
  import salamander_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      opcode,
  input  logic [SIZE-1:0] a_val,
  input  logic [SIZE-1:0] b_val,
  output logic [SIZE-1:0] res_val,
  output logic            res_ce,
  output logic [2:0]      flags,
  output alu_state_e      state_dbg
);

  logic            xfer;
  logic [SIZE-1:0] alu_res;
  logic            alu_c;
  logic            load;
  logic [SIZE-1:0] load_res;
  logic            load_c;

  assign xfer = op_valid & op_ready;

  // Single-cycle operations. Carry/borrow come from a one-bit-wider sum.
  always_comb begin
    alu_res = a_val;
    alu_c   = 1'b0;
    case (opcode)
      OP_ADD:  {alu_c, alu_res} = {1'b0, a_val} + {1'b0, b_val};
      OP_SUB:  {alu_c, alu_res} = {1'b0, a_val} - {1'b0, b_val};
      OP_AND:  alu_res = a_val & b_val;
      OP_OR:   alu_res = a_val | b_val;
      OP_XOR:  alu_res = a_val ^ b_val;
      OP_SHL: begin
        alu_res = {a_val[SIZE-2:0], 1'b0};
        alu_c   = a_val[SIZE-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_val[SIZE-1:1]};
        alu_c   = a_val[0];
      end
      // OP_MUL without the multiplier: pass-through NOP with C cleared.
      default: begin
        alu_res = a_val;
        alu_c   = 1'b0;
      end
    endcase
  end

`ifdef SALAMANDER_ALU_MUL_EN
  alu_state_e        state_q;
  alu_state_e        state_d;
  logic              mul_start;
  logic              mul_done;
  logic [2*SIZE-1:0] mul_prod;

  assign mul_start = xfer && (opcode == OP_MUL);
  assign op_ready  = (state_q == ST_IDLE);
  assign state_dbg = state_q;

  acu_mul_iter #(.SIZE(SIZE)) u_mul (
    .clk     (clk),
    .rstn    (rstn),
    .start   (mul_start),
    .a_val   (a_val),
    .b_val   (b_val),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (mul_start) state_d = ST_MUL_BUSY;
      ST_MUL_BUSY: if (mul_done)  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // A finishing multiply and a new transfer cannot coincide: op_ready is
  // low for the whole multiply.
  always_comb begin
    load     = 1'b0;
    load_res = alu_res;
    load_c   = alu_c;
    if (mul_done) begin
      load     = 1'b1;
      load_res = mul_prod[SIZE-1:0];
      load_c   = |mul_prod[2*SIZE-1:SIZE];
    end else if (xfer && (opcode != OP_MUL)) begin
      load = 1'b1;
    end
  end
`else
  assign op_ready  = 1'b1;
  assign state_dbg = ST_IDLE;
  assign load      = xfer;
  assign load_res  = alu_res;
  assign load_c    = alu_c;
`endif

  // res_ce is a pulse: cleared every cycle unless an op completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_val <= '0;
      res_ce  <= 1'b0;
      flags   <= '0;
    end else begin
      res_ce <= 1'b0;
      if (load) begin
        res_val <= load_res;
        res_ce  <= 1'b1;
        flags   <= pack_flags(load_c, (load_res == '0), load_res[SIZE-1]);
      end
    end
  end

endmodule

// File: tb/tb_acu_alu_stage.sv
module tb_acu_alu_stage;

  localparam int SIZE = 8;
  localparam int W    = SIZE + 3;   // {C,Z,N, result}
`ifdef SALAMANDER_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam longint unsigned MOD = 64'd1 << SIZE;

  localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_AND = 3'd2, C_OR = 3'd3,
                         C_XOR = 3'd4, C_SHL = 3'd5, C_SHR = 3'd6, C_MUL = 3'd7;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     op_valid;
  logic                     op_ready;
  logic [2:0]               opcode;
  logic [SIZE-1:0]          a_val;
  logic [SIZE-1:0]          b_val;
  logic [SIZE-1:0]          res_val;
  logic                     res_ce;
  logic [2:0]               flags;
  salamander_pkg::alu_state_e state_dbg;

  int checks   = 0;
  int failures = 0;

  // Reference model state: expected results in completion order, the cycle
  // each one must appear, the cycle from which the stage accepts again, and
  // the last value the outputs must hold.
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           cyc        = 0;
  int           busy_until = 0;
  logic [W-1:0] last_exp   = '0;

  acu_alu_stage #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .opcode    (opcode),
    .a_val     (a_val),
    .b_val     (b_val),
    .res_val   (res_val),
    .res_ce    (res_ce),
    .flags     (flags),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: result and {C,Z,N} straight from the operation rules.
  function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [SIZE-1:0] a,
                                             input logic [SIZE-1:0] b);
    longint unsigned av, bv, r, rm;
    bit c;
    av = a;
    bv = b;
    r  = 0;
    c  = 1'b0;
    case (op)
      C_ADD: begin r = av + bv; c = (r >= MOD); end
      C_SUB: begin r = av + MOD - bv; c = (av < bv); end
      C_AND: r = av & bv;
      C_OR:  r = av | bv;
      C_XOR: r = av ^ bv;
      C_SHL: begin r = av * 2; c = (av >= MOD / 2); end
      C_SHR: begin r = av / 2; c = (av % 2 == 1); end
      default: begin
        if (MUL_EN) begin r = av * bv; c = (r >= MOD); end
        else        begin r = av; c = 1'b0; end
      end
    endcase
    rm = r % MOD;
    return {c, (rm == 0), (rm >= MOD / 2), SIZE'(rm)};
  endfunction

  function automatic logic [SIZE-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return SIZE'(MOD / 2);
      3:       return SIZE'(MOD / 2 - 1);
      default: return SIZE'($urandom);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [SIZE-1:0] a,
                       input logic [SIZE-1:0] b);
    op_valid = v;
    opcode   = op;
    a_val    = a;
    b_val    = b;
  endtask

  task automatic model_reset();
    exp_q.delete();
    due_q.delete();
    busy_until = cyc;
    last_exp   = '0;
  endtask

  // One clock: predict any transfer, then check all outputs 1 time unit
  // after the edge.
  task automatic tick();
    bit           xfer;
    logic [W-1:0] e;
    xfer = (op_valid === 1'b1) && (rstn === 1'b1) && (cyc >= busy_until);
    @(posedge clk);
    cyc++;
    if (xfer) begin
      exp_q.push_back(ref_model(opcode, a_val, b_val));
      if (MUL_EN && opcode == C_MUL) begin
        due_q.push_back(cyc + SIZE);
        busy_until = cyc + SIZE;
      end else begin
        due_q.push_back(cyc);
      end
    end
    #1;
    chk("op_ready", op_ready, cyc >= busy_until);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      e        = exp_q.pop_front();
      last_exp = e;
      chk("res_ce_pulse", res_ce, 1'b1);
    end else begin
      chk("res_ce_idle", res_ce, 1'b0);
    end
    chk("res_val", res_val, last_exp[SIZE-1:0]);
    chk("flags", flags, last_exp[W-1:SIZE]);
  endtask

  initial begin
    // Reset held for two cycles with an op offered.
    rstn = 1'b0;
    drive(1'b1, C_ADD, 8'hF0, 8'h20);
    model_reset();
    tick();
    tick();
    chk("reset_op_ready", op_ready, 1'b1);
    chk("reset_res_val", res_val, 8'h00);
    rstn = 1'b1;

    // ADD overflow.
    tick();
    chk("add_res", res_val, 8'h10);
    chk("add_flags", flags, 3'b100);

    // SUB equal then borrow, back to back.
    drive(1'b1, C_SUB, 8'h55, 8'h55);
    tick();
    chk("sub_eq_res", res_val, 8'h00);
    chk("sub_eq_flags", flags, 3'b010);
    drive(1'b1, C_SUB, 8'h01, 8'h02);
    tick();
    chk("sub_borrow_ce", res_ce, 1'b1);
    chk("sub_borrow_res", res_val, 8'hFF);
    chk("sub_borrow_flags", flags, 3'b101);
    drive(1'b0, C_ADD, 8'h00, 8'h00);
    tick();

    // Shifts.
    drive(1'b1, C_SHL, 8'h81, 8'h00);
    tick();
    chk("shl_res", res_val, 8'h02);
    chk("shl_flags", flags, 3'b100);
    drive(1'b1, C_SHR, 8'h01, 8'h00);
    tick();
    chk("shr_res", res_val, 8'h00);
    chk("shr_flags", flags, 3'b110);

    // Unknown inputs while idle must not disturb anything.
    op_valid = 1'b0;
    opcode   = 'x;
    a_val    = 'x;
    b_val    = 'x;
    tick();
    tick();

`ifdef SALAMANDER_ALU_MUL_EN
    // 13*11 with junk offered (and ignored) while busy.
    drive(1'b1, C_MUL, 8'd13, 8'd11);
    tick();
    for (int i = 0; i < SIZE - 1; i++) begin
      drive(1'b1, C_ADD, pick(), pick());
      tick();
    end
    drive(1'b0, C_ADD, 8'h00, 8'h00);
    tick();
    chk("mul_13x11_res", res_val, 8'h8F);
    chk("mul_13x11_flags", flags, 3'b001);
    // 16*16 overflows to zero.
    drive(1'b1, C_MUL, 8'd16, 8'd16);
    tick();
    drive(1'b0, C_ADD, 8'h00, 8'h00);
    for (int i = 0; i < SIZE; i++) tick();
    chk("mul_16x16_res", res_val, 8'h00);
    chk("mul_16x16_flags", flags, 3'b110);
`else
    drive(1'b1, C_MUL, 8'hAA, 8'h55);
    tick();
    chk("nop_res", res_val, 8'hAA);
    chk("nop_flags", flags, 3'b001);
`endif

    // Randomized mix against the reference model.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), pick(), pick());
      tick();
    end
    drive(1'b0, C_ADD, 8'h00, 8'h00);
    for (int i = 0; i < SIZE + 2; i++) tick();

    // Reset in the middle of a multiply.
    drive(1'b1, C_ADD, 8'h01, 8'h01);
    tick();
    drive(1'b1, C_MUL, 8'd3, 8'd5);
    tick();
    drive(1'b0, C_ADD, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) tick();
`ifdef SALAMANDER_ALU_MUL_EN
    chk("mid_mul_busy", op_ready, 1'b0);
`endif
    rstn = 1'b0;
    model_reset();
    #1;
    chk("abort_res_ce", res_ce, 1'b0);
    chk("abort_res_val", res_val, 8'h00);
    chk("abort_flags", flags, 3'b000);
    chk("abort_op_ready", op_ready, 1'b1);
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < SIZE + 3; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
